// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants the shared cache bus to one requester per burst, held until the last beat.
// Define CBUS_ARB_RR_EN for round-robin selection; otherwise the lowest valid index wins.

package cbus_pkg;
    typedef enum logic [2:0] {MLEN1, MLEN2, MLEN4, MLEN8, MLEN16} cbus_len_t;
    typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} cbus_burst_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        cbus_len_t   len;
        cbus_burst_t burst;
        logic [31:0] data;
        logic [3:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned SEL_BITS   = $clog2(NUM_INPUTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  cbus_req_t           ireqs  [NUM_INPUTS],
    output cbus_resp_t          iresps [NUM_INPUTS],
    output cbus_req_t           oreq,
    input  cbus_resp_t          oresp,
    output logic                busy,
    output logic [SEL_BITS-1:0] grant_idx
);
    localparam int unsigned CW = SEL_BITS + 1;

    typedef enum logic {StIdle, StBusy} state_t;

    state_t              state_q;
    logic [SEL_BITS-1:0] sel_q;
    logic                busy_q;
    logic [SEL_BITS-1:0] pick;
    logic                any_valid;
    logic                release_grant;
`ifdef CBUS_ARB_RR_EN
    logic [SEL_BITS-1:0] ptr_q;
    logic [CW-1:0]       cand;
`endif

    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
`ifdef CBUS_ARB_RR_EN
        cand = '0;
        // Scan upward from ptr, wrapping modulo NUM_INPUTS; first valid wins.
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NUM_INPUTS)) begin
                cand = cand - CW'(NUM_INPUTS);
            end
            if (!any_valid && ireqs[cand[SEL_BITS-1:0]].valid) begin
                any_valid = 1'b1;
                pick      = cand[SEL_BITS-1:0];
            end
        end
`else
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            if (!any_valid && ireqs[SEL_BITS'(k)].valid) begin
                any_valid = 1'b1;
                pick      = SEL_BITS'(k);
            end
        end
`endif
    end

    assign release_grant = oresp.ready & oresp.last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
            busy_q  <= 1'b0;
`ifdef CBUS_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        state_q <= StBusy;
                        sel_q   <= pick;
                        busy_q  <= 1'b1;
                    end
                end
                StBusy: begin
                    if (release_grant) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
`ifdef CBUS_ARB_RR_EN
                        // Just-finished requester drops to lowest priority.
                        ptr_q <= (sel_q == SEL_BITS'(NUM_INPUTS - 1)) ? '0
                                                                       : sel_q + SEL_BITS'(1);
`endif
                    end
                end
            endcase
        end
    end

    always_comb begin
        oreq = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end
        if (state_q == StBusy) begin
            oreq          = ireqs[sel_q];
            iresps[sel_q] = oresp;
        end
    end

    assign busy      = busy_q;
    assign grant_idx = sel_q;

`ifndef SYNTHESIS
    // Granted requester must keep valid asserted until its last beat.
    valid_held_a: assert property (@(posedge clk) disable iff (!reset)
        (state_q == StBusy) |-> ireqs[sel_q].valid);
`endif

endmodule
